step_clock_gen: RTL

- Generates the datapath clock for the DE0 datapath test top, from the 50 MHz board clock and the raw step pushbutton.
- Sits directly upstream of the datapath's clock input and replaces the direct inversion of the key.
- Debounces the key and emits exactly one clean, fixed-width clock pulse per press in step mode.
- In run mode, emits a free-running divided clock.
- Counts issued datapath cycles for display on the GPIO row LEDs.

---
 rtl/step_clock_gen.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/step_clock_gen.sv
// Datapath clock generator: debounced single-step pulses or a free-running divided clock.
// Optional HOLD_REPEAT_EN: auto-repeat step pulses while the step key stays held.
module step_clock_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 25000,
    parameter int RUN_HALF        = 25000000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   step_key_n,
    input  logic                   run_sw,
    input  logic [2:0]             rate_sel,
    input  logic                   count_clr,
    output logic                   dp_clock,
    output logic                   step_pulse,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] cycle_count
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PH_MAX = (RUN_HALF > PULSE_CYCLES) ? RUN_HALF : PULSE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
`ifdef HOLD_REPEAT_EN
    localparam int HOLD_FIRST = 4 * DEBOUNCE_CYCLES;
    localparam int HOLD_REP   = 2 * RUN_HALF;
    localparam int REP_MAX0   = (HOLD_FIRST > HOLD_REP) ? HOLD_FIRST : HOLD_REP;
    localparam int REP_MAX    = (REP_MAX0 > PULSE_CYCLES) ? REP_MAX0 : PULSE_CYCLES;
    localparam int REP_W      = $clog2(REP_MAX + 2);
`endif

    typedef enum logic [1:0] {IDLE, STEP_HI, WAIT_REL, RUN} state_t;

    function automatic logic [PH_W-1:0] half_period(input logic [2:0] sel);
        int unsigned h;
        h = unsigned'(RUN_HALF) >> sel;
        if (h == 0) h = 1;
        return PH_W'(h);
    endfunction

    logic [1:0]             key_sync_q, run_sync_q;
    logic                   key_lvl, run_s;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   db_key_q, db_key_d;
    logic                   press_evt_q, press_evt_d;
    state_t                 state_q, state_d;
    logic [PH_W-1:0]        ph_cnt_q, ph_cnt_d;
    logic [PH_W-1:0]        ph_len_q, ph_len_d;
    logic                   dp_q, dp_d;
    logic                   pulse_q, rise;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef HOLD_REPEAT_EN
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic                   rep_arm_q, rep_arm_d;
    logic                   rep_first_q, rep_first_d;
    logic [REP_W-1:0]       rep_target;
`endif

    assign key_lvl = ~key_sync_q[1];
    assign run_s   = run_sync_q[1];

    always_comb begin
        db_cnt_d    = '0;
        db_key_d    = db_key_q;
        press_evt_d = 1'b0;
        if (key_lvl != db_key_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_key_d    = key_lvl;
                press_evt_d = key_lvl;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

`ifdef HOLD_REPEAT_EN
    assign rep_target = rep_first_q ? REP_W'(HOLD_FIRST - 1) : REP_W'(HOLD_REP - 1);
`endif

    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q + PH_W'(1);
        ph_len_d = ph_len_q;
        dp_d     = dp_q;
`ifdef HOLD_REPEAT_EN
        rep_cnt_d   = rep_arm_q ? rep_cnt_q + REP_W'(1) : '0;
        rep_arm_d   = rep_arm_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            IDLE: begin
                ph_cnt_d = '0;
                dp_d     = 1'b0;
`ifdef HOLD_REPEAT_EN
                rep_arm_d   = 1'b0;
                rep_first_d = 1'b1;
`endif
                if (run_s) begin
                    state_d  = RUN;
                    dp_d     = 1'b1;
                    ph_len_d = half_period(rate_sel);
                end else if (press_evt_q) begin
                    state_d = STEP_HI;
                    dp_d    = 1'b1;
`ifdef HOLD_REPEAT_EN
                    rep_arm_d = 1'b1;
                    rep_cnt_d = '0;
`endif
                end
            end
            STEP_HI: begin
                if (ph_cnt_q == PH_W'(PULSE_CYCLES - 1)) begin
                    ph_cnt_d = '0;
                    dp_d     = 1'b0;
                    state_d  = db_key_q ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                ph_cnt_d = '0;
                dp_d     = 1'b0;
                if (!db_key_q) begin
                    state_d = IDLE;
`ifdef HOLD_REPEAT_EN
                end else if (rep_arm_q && rep_cnt_q >= rep_target) begin
                    state_d     = STEP_HI;
                    dp_d        = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef HOLD_REPEAT_EN
                rep_arm_d = 1'b0;
`endif
                // Phase boundaries are the only place the rate or the run switch take effect.
                if (ph_cnt_q == ph_len_q - PH_W'(1)) begin
                    ph_cnt_d = '0;
                    ph_len_d = half_period(rate_sel);
                    if (run_s) begin
                        dp_d = ~dp_q;
                    end else begin
                        dp_d    = 1'b0;
                        state_d = db_key_q ? WAIT_REL : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                dp_d    = 1'b0;
            end
        endcase
    end

    assign rise = dp_d & ~dp_q;

    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) cnt_d = '0;
        else if (rise) cnt_d = cnt_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_sync_q  <= 2'b11;
            run_sync_q  <= 2'b00;
            db_cnt_q    <= '0;
            db_key_q    <= 1'b0;
            press_evt_q <= 1'b0;
            state_q     <= IDLE;
            ph_cnt_q    <= '0;
            ph_len_q    <= PH_W'(1);
            dp_q        <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
`ifdef HOLD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_arm_q   <= 1'b0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            key_sync_q  <= {key_sync_q[0], step_key_n};
            run_sync_q  <= {run_sync_q[0], run_sw};
            db_cnt_q    <= db_cnt_d;
            db_key_q    <= db_key_d;
            press_evt_q <= press_evt_d;
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            ph_len_q    <= ph_len_d;
            dp_q        <= dp_d;
            pulse_q     <= rise;
            cnt_q       <= cnt_d;
`ifdef HOLD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_arm_q   <= rep_arm_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign dp_clock    = dp_q;
    assign step_pulse  = pulse_q;
    assign running     = (state_q == RUN);
    assign cycle_count = cnt_q;
endmodule
